skeleton_pass_sequencer: RTL
============================

// Module: skeleton_pass_sequencer
// PURPOSE
//  Sequences the kernelRam convolution array over one NxN 8-bit frame held in a frame buffer.
//  Each pass has two sweeps over addresses 0..N*N-1, one beat per address:
//  LOAD sweep streams pixels into the array; READOUT sweep collects the result pixels and writes them back.
//  Passes repeat until a pass changes no pixel, or MAX_PASSES is reached; this gives iterative border peeling.
//  Sits between the top-level frame buffer and the bank of kernelRam instances (shared we/address/data bus).
// PARAMETERS
//  N          8   image side length; pixel count is N*N
//  BIT_SIZE   6   address MSB index; address width is BIT_SIZE+1 (must hold N*N-1)
//  MAX_PASSES 15  pass limit; pass_count width is $clog2(MAX_PASSES+1)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  start        in   1            1-cycle pulse; sampled only in IDLE
//  busy         out  1            high from the cycle after start until the done pulse
//  done         out  1            1-cycle pulse when processing ends
//  converged    out  1            valid with done: 1 = last pass changed no pixel
//  pass_count   out  PC_W         passes completed; held after done; cleared on start
//  beat_phase   out  1            0 = kernel array's active edge cycle; array flip must align to it
//  k_we         out  1            kernel write enable (1 in LOAD, 0 in READOUT)
//  k_addr       out  BIT_SIZE+1   kernel pixel_position_or_address
//  k_data       out  8            kernel data_in
//  k_result     in   8            merged primary_output of the array for k_addr
//  fb_rd_addr   out  BIT_SIZE+1   frame buffer read address; read data arrives 1 cycle later
//  fb_rd_data   in   8            frame buffer read data
//  fb_wr_en     out  1            frame buffer write strobe
//  fb_wr_addr   out  BIT_SIZE+1   frame buffer write address
//  fb_wr_data   out  8            frame buffer write data
// BEHAVIOUR
//  Reset: all outputs 0; k_addr, fb_* 0; state IDLE; beat_phase 0. Reset mid-pass aborts with no done pulse.
//  Beat = 2 clk cycles. k_we, k_addr and k_data are registered and held constant for both cycles of a beat.
//  beat_phase toggles every cycle from reset.
//  FSM: IDLE -> PREFETCH -> LOAD -> TURN -> READOUT -> CHECK -> (PREFETCH | FINISH) -> IDLE.
//  IDLE: on start, clear pass_count and the changed flag, set busy, go to PREFETCH.
//  PREFETCH (1 beat): fb_rd_addr=0; latch fb_rd_data into the prefetch register in cycle 1.
//  LOAD (N*N beats, a=0..N*N-1):
//   - present k_we=1, k_addr=a, k_data=prefetch(a);
//   - in cycle 0 issue fb_rd_addr=a+1 (suppressed at a=N*N-1); latch the result in cycle 1.
//  TURN (1 beat): k_we=0, k_addr=0. Lets the array's last-address compute occur.
//  READOUT (N*N beats, a=0..N*N-1):
//   - k_we=0, k_addr=a; cycle 0 issues fb_rd_addr=a (old pixel);
//   - cycle 1 samples k_result, writes fb_wr_en=1, fb_wr_addr=a, fb_wr_data=k_result;
//   - sets changed if k_result != fb_rd_data. Exactly one write per address per pass.
//  CHECK (1 cycle): pass_count+1 (saturates at MAX_PASSES).
//   - if changed==0: converged=1 -> FINISH.
//   - else if pass_count+1==MAX_PASSES: converged=0 -> FINISH.
//   - else clear changed -> PREFETCH.
//  FINISH: done=1 for 1 cycle, busy=0, -> IDLE.
//  start while busy is ignored. A start in the same cycle as done is ignored; it is accepted only in IDLE.
//  Address counter wraps only via FSM exit; it never exceeds N*N-1. Comparisons use full BIT_SIZE+1 width.
//  Latency per pass: 2*(1 + N*N + 1 + N*N) + 1 cycles (N=8: 261). done follows the last CHECK by 1 cycle.
// STRUCTURE
//  Shared package skel_pkg:
//   - typedef enum seq_state_t {IDLE, PREFETCH, LOAD, TURN, READOUT, CHECK, FINISH};
//   - localparam PIX_W=8; function pix_count(N).
//  One sub-module, beat_addr_gen: beat_phase toggle plus address counter with last-address flag, reused by LOAD and READOUT.
// TESTING
//  1 reset mid-LOAD (a=20) -> all outputs 0 next cycle, busy=0, no done; a later start runs a clean pass.
//  2 uniform frame all 0x80, start -> 1 pass, 64 writes of 0x80, done with converged=1, pass_count=1, 261 cycles busy.
//  3 4x4 block of 0xFF at rows/cols 2..5 on 0x00, kernel model -> pass 1 peels the border.
//   - pass 2: no change; converged=1, pass_count=2.
//  4 model that always inverts a pixel, MAX_PASSES=3 -> done after 3 passes, converged=0, pass_count=3.
//  5 start pulsed during READOUT and on the done cycle -> ignored; pass_count and write sequence unchanged.
//  6 protocol check -> k_addr/k_data stable across each beat; fb_rd_addr never issued at 64 in LOAD.
//   - fb_wr_addr sequence is 0..63 exactly once per pass.

Source files
------------

// File: rtl/skel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : skel_pkg
//  Description : Shared types and helpers for the skeleton pass sequencer.
//                Holds the sequencer state encoding, pixel width and a pixel
//                count helper used to size the address sweep.
//  Revision    : 1.0  initial release
// ============================================================================
package skel_pkg;

    localparam int PIX_W = 8;

    // Sequencer states. A pass is PREFETCH -> LOAD -> TURN -> READOUT -> CHECK.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        LOAD     = 3'd2,
        TURN     = 3'd3,
        READOUT  = 3'd4,
        CHECK    = 3'd5,
        FINISH   = 3'd6
    } seq_state_t;

    // Number of pixels in an n x n frame.
    function automatic int pix_count(input int n);
        return n * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : beat_addr_gen
//  Description : Beat phase toggle and sweep address counter. The phase bit
//                toggles every cycle and can be restarted at 0 so that a new
//                pass begins on the kernel array's active-edge cycle. The
//                address counter steps once per beat and flags the last pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module beat_addr_gen
    import skel_pkg::*;
#(
    parameter int N        = 8,
    parameter int BIT_SIZE = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                phase_restart,
    input  logic                addr_step,
    input  logic                addr_clear,
    output logic                beat_phase,
    output logic [BIT_SIZE:0]   addr,
    output logic                addr_last
);

    localparam logic [BIT_SIZE:0] c_last_addr = (BIT_SIZE+1)'(pix_count(N) - 1);

    logic              r_phase;
    logic [BIT_SIZE:0] r_addr;

    // Phase bit: free-running toggle, forced back to 0 at the start of a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
        end else if (phase_restart) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    // Address counter: cleared by the FSM when a sweep ends, never passes the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (addr_clear) begin
            r_addr <= '0;
        end else if (addr_step && (r_addr != c_last_addr)) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign beat_phase = r_phase;
    assign addr       = r_addr;
    assign addr_last  = (r_addr == c_last_addr);

endmodule
`default_nettype wire

// File: rtl/skeleton_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : skeleton_pass_sequencer
//  Description : Drives the kernelRam convolution array over one NxN frame.
//                Each pass streams the frame into the array (LOAD), lets the
//                array finish (TURN), then writes every result pixel back to
//                the frame buffer (READOUT). Passes repeat until a pass leaves
//                the frame unchanged or the pass limit is reached.
//                The beat phase is restarted at 0 on the first beat of every
//                pass so that beats stay aligned with the array's active edge
//                across the single-cycle CHECK state.
//  Revision    : 1.0  initial release
// ============================================================================
module skeleton_pass_sequencer
    import skel_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int BIT_SIZE   = 6,
    parameter  int MAX_PASSES = 15,
    localparam int PC_W       = $clog2(MAX_PASSES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [PC_W-1:0]     pass_count,
    output logic                beat_phase,
    output logic                k_we,
    output logic [BIT_SIZE:0]   k_addr,
    output logic [PIX_W-1:0]    k_data,
    input  logic [PIX_W-1:0]    k_result,
    output logic [BIT_SIZE:0]   fb_rd_addr,
    input  logic [PIX_W-1:0]    fb_rd_data,
    output logic                fb_wr_en,
    output logic [BIT_SIZE:0]   fb_wr_addr,
    output logic [PIX_W-1:0]    fb_wr_data
);

    localparam logic [PC_W-1:0] c_max_pass = PC_W'(MAX_PASSES);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic              r_changed;
    logic              r_converged;
    logic [PC_W-1:0]   r_pass_count;
    logic [PC_W-1:0]   w_pc_next;
    logic              r_k_we;
    logic [PIX_W-1:0]  r_prefetch;

    logic              w_phase;
    logic [BIT_SIZE:0] w_addr;
    logic              w_last;
    logic              w_phase_restart;
    logic              w_addr_step;
    logic              w_addr_clear;

    beat_addr_gen #(
        .N        (N),
        .BIT_SIZE (BIT_SIZE)
    ) u_beat_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .phase_restart (w_phase_restart),
        .addr_step     (w_addr_step),
        .addr_clear    (w_addr_clear),
        .beat_phase    (w_phase),
        .addr          (w_addr),
        .addr_last     (w_last)
    );

    // Saturating pass counter increment used by CHECK.
    assign w_pc_next = (r_pass_count == c_max_pass) ? r_pass_count : r_pass_count + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; beat states advance only at the end of phase 1.
    always_comb begin
        w_state_next    = r_state;
        w_phase_restart = 1'b0;
        w_addr_step     = 1'b0;
        w_addr_clear    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next    = PREFETCH;
                    w_phase_restart = 1'b1;
                end
            end
            PREFETCH: begin
                if (w_phase) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_phase) begin
                    if (w_last) begin
                        w_state_next = TURN;
                        w_addr_clear = 1'b1;
                    end else begin
                        w_addr_step  = 1'b1;
                    end
                end
            end
            TURN: begin
                if (w_phase) begin
                    w_state_next = READOUT;
                end
            end
            READOUT: begin
                if (w_phase) begin
                    if (w_last) begin
                        w_state_next = CHECK;
                        w_addr_clear = 1'b1;
                    end else begin
                        w_addr_step  = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (!r_changed || (w_pc_next == c_max_pass)) begin
                    w_state_next = FINISH;
                end else begin
                    w_state_next    = PREFETCH;
                    w_phase_restart = 1'b1;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pass bookkeeping: change detection during READOUT, verdict in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed    <= 1'b0;
            r_converged  <= 1'b0;
            r_pass_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_changed    <= 1'b0;
                        r_converged  <= 1'b0;
                        r_pass_count <= '0;
                    end
                end
                READOUT: begin
                    if (w_phase && (k_result != fb_rd_data)) begin
                        r_changed <= 1'b1;
                    end
                end
                CHECK: begin
                    r_pass_count <= w_pc_next;
                    if (!r_changed) begin
                        r_converged <= 1'b1;
                    end else if (w_pc_next == c_max_pass) begin
                        r_converged <= 1'b0;
                    end else begin
                        r_changed <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Kernel write enable and prefetched pixel, both stable across a full beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k_we     <= 1'b0;
            r_prefetch <= '0;
        end else begin
            r_k_we <= (w_state_next == LOAD);
            if (w_phase && (r_state == PREFETCH)) begin
                r_prefetch <= fb_rd_data;
            end else if (w_phase && (r_state == LOAD)) begin
                r_prefetch <= w_last ? '0 : fb_rd_data;
            end
        end
    end

    // Frame buffer read address and write-back strobe.
    always_comb begin
        fb_rd_addr = '0;
        fb_wr_en   = 1'b0;
        fb_wr_addr = '0;
        fb_wr_data = '0;
        case (r_state)
            LOAD: begin
                fb_rd_addr = w_last ? '0 : (w_addr + 1'b1);
            end
            READOUT: begin
                fb_rd_addr = w_addr;
                if (w_phase) begin
                    fb_wr_en   = 1'b1;
                    fb_wr_addr = w_addr;
                    fb_wr_data = k_result;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy       = (r_state != IDLE) && (r_state != FINISH);
    assign done       = (r_state == FINISH);
    assign converged  = r_converged;
    assign pass_count = r_pass_count;
    assign beat_phase = w_phase;
    assign k_we       = r_k_we;
    assign k_addr     = w_addr;
    assign k_data     = r_prefetch;

endmodule
`default_nettype wire
